// File: rtl/spi_byte_master_pkg.sv
// spi_byte_master_pkg: shared SPI state encoding, flash opcodes and timing defaults
package spi_byte_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DONE  = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    localparam logic [7:0] OP_READ_ID = 8'h90;
    localparam logic [7:0] OP_READ    = 8'h03;
    localparam logic [7:0] OP_WREN    = 8'h06;

    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_CS_SETUP = 2;
    localparam int DEF_CS_IDLE  = 16;

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: SCLK half-period counter producing alternating rise/fall ticks while enabled
module spi_clk_div
    import spi_byte_master_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_rise_tick,
    output logic o_fall_tick
);

    localparam int HW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    logic [HW-1:0] r_cnt;
    logic          r_phase;
    logic          w_end;

    assign w_end       = i_en && (r_cnt == HW'(CLK_DIV - 1));
    assign o_rise_tick = w_end && !r_phase;
    assign o_fall_tick = w_end && r_phase;

    // count out each half-period; the first tick after enable is always a rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (!i_en) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_end) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_byte_master.sv
// spi_byte_master: mode-0 SPI byte master keeping CS low across back-to-back bytes
module spi_byte_master
    import spi_byte_master_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int CS_SETUP = DEF_CS_SETUP,
    parameter int CS_IDLE  = DEF_CS_IDLE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_spi_start,
    input  logic       i_spi_we,
    input  logic [7:0] i_wdata,
    output logic [7:0] o_rdata,
    output logic       o_spi_done,
    output logic       o_busy,
    output logic       o_sclk,
    output logic       o_cs_n,
    output logic       o_mosi,
    input  logic       i_miso
);

    localparam int CW = $clog2((CS_SETUP > CS_IDLE ? CS_SETUP : CS_IDLE) + 1);

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_bit_cnt;
    logic [7:0]    r_tx, r_rx, r_rdata;
    logic          r_sclk, r_cs_n, r_done, r_busy;
    logic          w_load, w_rise, w_fall;

    assign w_load     = i_spi_start && (r_state == ST_IDLE || r_state == ST_HOLD);
    assign o_rdata    = r_rdata;
    assign o_spi_done = r_done;
    assign o_busy     = r_busy;
    assign o_sclk     = r_sclk;
    assign o_cs_n     = r_cs_n;
    assign o_mosi     = r_tx[7];

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (r_state == ST_SHIFT),
        .o_rise_tick(w_rise),
        .o_fall_tick(w_fall)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // next state; a start in HOLD beats the idle timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_spi_start) w_next = ST_SETUP;
            ST_SETUP: if (r_cnt == CW'(CS_SETUP - 1)) w_next = ST_SHIFT;
            ST_SHIFT: if (w_fall && r_bit_cnt == 4'd7) w_next = ST_DONE;
            ST_DONE:  w_next = ST_HOLD;
            ST_HOLD:  if (i_spi_start) w_next = ST_SHIFT;
                      else if (r_cnt == CW'(CS_IDLE - 1)) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // datapath and registered outputs, all derived from the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rdata   <= '0;
            r_sclk    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_cnt <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
            if (w_load) begin
                r_tx      <= i_spi_we ? i_wdata : 8'h00;
                r_bit_cnt <= '0;
            end else if (w_fall) begin
                r_tx      <= {r_tx[6:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_rise) r_rx <= {r_rx[6:0], i_miso};
            if (w_next == ST_DONE) r_rdata <= r_rx;
            r_sclk <= (w_next == ST_SHIFT) && (w_rise || (r_sclk && !w_fall));
            r_cs_n <= (w_next == ST_IDLE);
            r_done <= (w_next == ST_DONE);
            r_busy <= (w_next == ST_SETUP) || (w_next == ST_SHIFT) || (w_next == ST_DONE);
        end
    end

endmodule

// File: tb/tb_spi_byte_master.sv
// tb_spi_byte_master: table-driven SPI byte master bench with a mode-0 slave model
module tb_spi_byte_master;
    import spi_byte_master_pkg::*;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       i_spi_start = 1'b0, i_spi_we = 1'b0, i_miso = 1'b0;
    logic [7:0] i_wdata = 8'h00, o_rdata;
    logic       o_spi_done, o_busy, o_sclk, o_cs_n, o_mosi;
    int         cyc = 0, checks = 0, errors = 0;

    typedef struct {
        logic       we;
        logic [7:0] wdata;
        logic [7:0] sbyte;
        logic [7:0] exp_mosi;
        logic [7:0] exp_rdata;
        int         gap;
        int         exp_lat;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    spi_byte_master #(.CLK_DIV(2), .CS_SETUP(2), .CS_IDLE(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_spi_start(i_spi_start),
        .i_spi_we   (i_spi_we),
        .i_wdata    (i_wdata),
        .o_rdata    (o_rdata),
        .o_spi_done (o_spi_done),
        .o_busy     (o_busy),
        .o_sclk     (o_sclk),
        .o_cs_n     (o_cs_n),
        .o_mosi     (o_mosi),
        .i_miso     (i_miso)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Launch one byte at the current negedge and follow it to spi_done, acting as the slave.
    // Latency is reported in spec terms: spi_done seen after edge t0+L-1 gives L.
    task automatic run_byte(input logic we, input logic [7:0] wd, input logic [7:0] sb, input int pulse_at,
                            output int lat, output logic [7:0] mcap, output logic [7:0] rd,
                            output logic cs_first, output logic cs_hi, output logic mosi_hi);
        int   t0;
        int   sidx;
        logic prev;
        lat = -1; mcap = 8'h00; rd = 8'h00; cs_first = 1'b1; cs_hi = 1'b0; mosi_hi = 1'b0;
        sidx = 0; prev = 1'b0;
        i_spi_we = we; i_wdata = wd; i_miso = sb[7]; i_spi_start = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        i_spi_start = 1'b0;
        for (int n = 0; n < 200 && lat < 0; n++) begin
            @(negedge clk);
            if (n == 0) cs_first = o_cs_n;
            if (o_cs_n) cs_hi = 1'b1;
            if (o_mosi) mosi_hi = 1'b1;
            if (o_sclk && !prev) mcap = {mcap[6:0], o_mosi};
            if (!o_sclk && prev) begin
                sidx++;
                i_miso = (sidx < 8) ? sb[7 - sidx] : 1'b0;
            end
            prev = o_sclk;
            if (o_spi_done) begin
                lat = cyc - t0 + 1;
                rd  = o_rdata;
            end
            if (n == pulse_at) i_spi_start = 1'b1;
            else if (n == pulse_at + 1) i_spi_start = 1'b0;
        end
        if (lat < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_idle(output int k);
        k = -1;
        for (int n = 1; n <= 100 && k < 0; n++) begin
            @(negedge clk);
            if (o_cs_n) k = n;
        end
    endtask

    task automatic count_dones(input int cycles, output int dn);
        dn = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (o_spi_done) dn++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat, k, dn, seq_dn;
        logic [7:0] mcap, rd;
        logic       cs_first, cs_hi, mosi_hi, gap_hi;

        vecs[0] = '{1'b1, 8'hA5,      8'h81, 8'hA5, 8'h81, 0, 35};
        vecs[1] = '{1'b0, 8'hFF,      8'h3C, 8'h00, 8'h3C, 0, 35};
        vecs[2] = '{1'b1, OP_READ_ID, 8'h00, 8'h90, 8'h00, 0, 35};
        vecs[3] = '{1'b1, 8'h00,      8'h66, 8'h00, 8'h66, 2, 33};
        vecs[4] = '{1'b1, OP_READ_ID, 8'h00, 8'h90, 8'h00, 0, 35};
        vecs[5] = '{1'b1, 8'h00,      8'h00, 8'h00, 8'h00, 2, 33};
        vecs[6] = '{1'b1, 8'h00,      8'h00, 8'h00, 8'h00, 3, 33};
        vecs[7] = '{1'b1, 8'h00,      8'h00, 8'h00, 8'h00, 2, 33};
        vecs[8] = '{1'b0, 8'h00,      8'hEF, 8'h00, 8'hEF, 2, 33};
        vecs[9] = '{1'b0, 8'h00,      8'h17, 8'h00, 8'h17, 4, 33};

        repeat (3) @(negedge clk);
        chk("rst_cs_n", o_cs_n, 1);
        chk("rst_sclk", o_sclk, 0);
        chk("rst_mosi", o_mosi, 0);
        chk("rst_done", o_spi_done, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_rdata", o_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        seq_dn = 0;
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].gap == 0) begin
                if (i > 0) begin
                    wait_idle(k);
                    chk($sformatf("v%0d_cs_release", i), k, 17);
                end
            end else begin
                gap_hi = 1'b0;
                repeat (vecs[i].gap - 1) begin
                    @(negedge clk);
                    if (o_cs_n) gap_hi = 1'b1;
                end
                chk($sformatf("v%0d_gap_cs", i), gap_hi, 0);
            end
            run_byte(vecs[i].we, vecs[i].wdata, vecs[i].sbyte, -1, lat, mcap, rd, cs_first, cs_hi, mosi_hi);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_mosi", i), mcap, vecs[i].exp_mosi);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("v%0d_cs_first", i), cs_first, 0);
            chk($sformatf("v%0d_cs_hi", i), cs_hi, 0);
            chk($sformatf("v%0d_mosi_hi", i), mosi_hi, vecs[i].exp_mosi != 8'h00);
            if (i >= 4 && lat > 0) seq_dn++;
        end
        chk("seq_dones", seq_dn, 6);

        gap_hi = 1'b0;
        repeat (16) begin
            @(negedge clk);
            if (o_cs_n) gap_hi = 1'b1;
        end
        chk("coll_pre_cs", gap_hi, 0);
        run_byte(1'b1, 8'h3C, 8'h99, -1, lat, mcap, rd, cs_first, cs_hi, mosi_hi);
        chk("coll_cs_first", cs_first, 0);
        chk("coll_cs_hi", cs_hi, 0);
        chk("coll_lat", lat, 33);
        chk("coll_mosi", mcap, 8'h3C);
        chk("coll_rdata", rd, 8'h99);

        wait_idle(k);
        chk("coll_cs_release", k, 17);
        run_byte(1'b1, 8'h5A, 8'hC3, 10, lat, mcap, rd, cs_first, cs_hi, mosi_hi);
        chk("ign_lat", lat, 35);
        chk("ign_mosi", mcap, 8'h5A);
        chk("ign_rdata", rd, 8'hC3);
        count_dones(50, dn);
        chk("ign_extra_dones", dn, 0);
        chk("ign_cs_idle", o_cs_n, 1);

        i_spi_we = 1'b1; i_wdata = 8'hFF; i_spi_start = 1'b1;
        @(posedge clk); #1;
        i_spi_start = 1'b0;
        repeat (10) @(negedge clk);
        for (int n = 0; n < 20 && !o_sclk; n++) @(negedge clk);
        chk("prerst_sclk", o_sclk, 1);
        chk("prerst_busy", o_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_cs_n", o_cs_n, 1);
        chk("rst_async_sclk", o_sclk, 0);
        chk("rst_async_busy", o_busy, 0);
        chk("rst_async_rdata", o_rdata, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        count_dones(50, dn);
        chk("rst_no_done", dn, 0);
        chk("rst_cs_idle", o_cs_n, 1);

        run_byte(1'b0, 8'h00, 8'h5A, -1, lat, mcap, rd, cs_first, cs_hi, mosi_hi);
        chk("recov_lat", lat, 35);
        chk("recov_rdata", rd, 8'h5A);
        chk("recov_mosi", mcap, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
